// File: rtl/btn_pkg.sv
// Shared definitions for the button debouncer: per-channel FSM state
// encoding and the stability-counter width helper.
package btn_pkg;

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_WAIT_HIGH = 2'd1,
        S_HIGH      = 2'd2,
        S_WAIT_LOW  = 2'd3
    } state_t;

    // Width of a counter that can hold values 0..stable.
    function automatic int cnt_width(input int stable);
        return $clog2(stable + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Bundle of raw button inputs and conditioned outputs.
// master drives btn_raw; slave (the debouncer) drives level/rise/fall.
interface btn_debounce_if #(
    parameter int N = 5
);

    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_rise;
    logic [N-1:0] btn_fall;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_rise,
        input  btn_fall
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_rise,
        output btn_fall
    );

endinterface

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser chain, stability FSM/counter and
// registered level/rise/fall. Ports: clk, rst_n (sync, active-low),
// raw (async in), level, rise, fall (registered outs).
module debounce_ch
    import btn_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int W = cnt_width(STABLE_CYCLES);
    localparam logic [W-1:0] LAST = W'(STABLE_CYCLES - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;

    state_t         state;
    state_t         state_nx;
    logic [W-1:0]   cnt;
    logic [W-1:0]   cnt_nx;
    logic           level_nx;
    logic           rise_nx;
    logic           fall_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_LOW;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            level <= level_nx;
            rise  <= rise_nx;
            fall  <= fall_nx;
        end
    end

    // Entering a WAIT state already counts the first new sample,
    // so completion is at cnt == STABLE_CYCLES-1.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        level_nx = level;
        rise_nx  = 1'b0;
        fall_nx  = 1'b0;
        unique case (state)
            S_LOW: begin
                if (s) begin
                    state_nx = S_WAIT_HIGH;
                    cnt_nx   = ONE;
                end else begin
                    cnt_nx = '0;
                end
            end
            S_WAIT_HIGH: begin
                if (!s) begin
                    state_nx = S_LOW;
                    cnt_nx   = '0;
                end else if (cnt == LAST) begin
                    state_nx = S_HIGH;
                    cnt_nx   = '0;
                    level_nx = 1'b1;
                    rise_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end
            S_HIGH: begin
                if (!s) begin
                    state_nx = S_WAIT_LOW;
                    cnt_nx   = ONE;
                end else begin
                    cnt_nx = '0;
                end
            end
            S_WAIT_LOW: begin
                if (s) begin
                    state_nx = S_HIGH;
                    cnt_nx   = '0;
                end else if (cnt == LAST) begin
                    state_nx = S_LOW;
                    cnt_nx   = '0;
                    level_nx = 1'b0;
                    fall_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end
        endcase
    end

endmodule

// File: rtl/btn_debounce.sv
// N independent debounce channels. Ports: clk, rst_n (sync,
// active-low), bus (slave: btn_raw in; btn_level/rise/fall out).
module btn_debounce #(
    parameter int N             = 5,
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    btn_debounce_if.slave  bus
);

    for (genvar i = 0; i < N; i++) begin : g_ch
        debounce_ch #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (bus.btn_raw[i]),
            .level (bus.btn_level[i]),
            .rise  (bus.btn_rise[i]),
            .fall  (bus.btn_fall[i])
        );
    end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Conditioning stage for raw push-button and switch inputs on the board.
- Synchronises each asynchronous input into the clk domain and filters contact bounce with a per-channel counter FSM.
- Emits a clean level plus one-cycle rise/fall strobes.
- Its btn_level outputs feed the single-bit D-type edge registers and the CPU's step/run control downstream.

Parameters:
- N, 5, number of independent input channels.
- STABLE_CYCLES, 4, consecutive synchronised samples at the new value needed to accept a change; legal range 2..2^20.
- SYNC_STAGES, 2, depth of the synchroniser flop chain; legal values 2 or 3.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- btn_raw  input  N  raw asynchronous button/switch levels.
- btn_level  output  N  debounced level, registered.
- btn_rise  output  N  one-cycle strobe when btn_level goes 0->1, registered.
- btn_fall  output  N  one-cycle strobe when btn_level goes 1->0, registered.

Behaviour:
- Reset: sampled at posedge clk while rst_n==0. Clears all synchroniser flops, btn_level, btn_rise, btn_fall, counters, and sets state=S_LOW on every channel. rst_n has no asynchronous effect.
- Synchroniser: per channel, SYNC_STAGES flops in series; s = last stage output.
- Counter width: $clog2(STABLE_CYCLES+1); it never exceeds STABLE_CYCLES-1.
- Per-channel FSM states: S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW.
  - S_LOW: s==1 -> S_WAIT_HIGH, cnt<=1; else hold, cnt<=0.
  - S_WAIT_HIGH: s==0 -> S_LOW, cnt<=0 (glitch rejected). Else if cnt==STABLE_CYCLES-1 -> S_HIGH, btn_level<=1, btn_rise<=1, cnt<=0. Else cnt<=cnt+1.
  - S_HIGH: s==0 -> S_WAIT_LOW, cnt<=1; else hold.
  - S_WAIT_LOW: mirror of S_WAIT_HIGH. s==1 -> S_HIGH (reject). On count complete -> S_LOW, btn_level<=0, btn_fall<=1.
- Strobes: btn_rise and btn_fall default to 0 every cycle and are high for exactly one cycle per accepted transition. They are never both high on one channel.
- Latency: raw value first captured at edge k gives btn_level updated at edge k+SYNC_STAGES+STABLE_CYCLES-1. The strobe is asserted in the same cycle as the btn_level update.
- Glitch: any excursion shorter than STABLE_CYCLES synchronised samples produces no output change. Any counting restarts from scratch on a reversal.
- Channels are fully independent; simultaneous transitions on several channels are each handled with identical timing.
- Reset mid-count: the count is discarded and any pending strobe is suppressed. After rst_n returns high, an input still held at 1 is treated as a new press: btn_rise fires after the normal latency.
- btn_level never changes outside S_WAIT_* completion edges; holds indefinitely while input stable.

Decomposition:
- Shared package btn_pkg holds:
  - the 2-bit state encoding constants S_LOW=0, S_WAIT_HIGH=1, S_HIGH=2, S_WAIT_LOW=3;
  - a cnt_width function (clog2 of STABLE_CYCLES+1).
- One sub-module, debounce_ch: a single channel containing its synchroniser, FSM, counter and strobe registers.
- btn_debounce instantiates N copies in a generate loop and contains no other logic.

Test Plan:
1. Reset hold: rst_n=0 for 3 cycles with btn_raw=5'b11111 -> all outputs 0 during reset. After release, with defaults, btn_rise=5'b11111 pulses for one cycle at the 5th edge after release and btn_level=5'b11111 from then on.
2. Clean press, ch0, defaults: btn_raw[0] 0->1 captured at edge 10 -> btn_level[0]=1 and btn_rise[0]=1 at edge 15. btn_rise[0]=0 at edge 16. Other channels stay 0.
3. Bounce reject: btn_raw[1] toggles 1,0,1,0,1 every 2 cycles, then holds 1 -> no output change during the toggling. A single rise strobe occurs 5 edges after the final stable capture.
4. Release: with btn_level[2]=1, btn_raw[2] -> 0 captured at edge 40 -> btn_fall[2] pulses and btn_level[2]=0 at edge 45. btn_rise[2] stays 0.
5. Short pulse: btn_raw[3]=1 for 3 cycles only with STABLE_CYCLES=4 -> btn_level[3] stays 0 and no strobes occur.
6. Reset mid-count: btn_raw[4] rises, and rst_n is pulled low 2 cycles into S_WAIT_HIGH -> no strobe during reset. The counter restarts after release and btn_rise[4] fires 5 edges after release.
